// File: rtl/prn_memcode_arbiter_if.sv
// Bundle of the channel, host and code-memory buses around the code-memory arbiter.
// The slave modport is the arbiter's side; the master modport drives requests and returns memory data.
interface prn_memcode_arbiter_if #(parameter int CH_NUM = 4);
  logic [CH_NUM-1:0]    ch_rd;
  logic [14*CH_NUM-1:0] ch_addr;
  logic [CH_NUM-1:0]    ch_read_valid;
  logic [31:0]          ch_data;
  logic                 host_cs;
  logic                 host_wr;
  logic [13:0]          host_addr;
  logic [31:0]          host_wdata;
  logic [31:0]          host_rdata;
  logic                 host_ready;
  logic                 mem_en;
  logic                 mem_we;
  logic [13:0]          mem_addr;
  logic [31:0]          mem_wdata;
  logic [31:0]          mem_rdata;

  modport slave (
    input  ch_rd, ch_addr, host_cs, host_wr, host_addr, host_wdata, mem_rdata,
    output ch_read_valid, ch_data, host_rdata, host_ready,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ch_rd, ch_addr, host_cs, host_wr, host_addr, host_wdata, mem_rdata,
    input  ch_read_valid, ch_data, host_rdata, host_ready,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prn_memcode_arbiter.sv
// Single-port code-memory arbiter: the host has strict priority, and the PRN channels share
// the remaining slots round-robin. Grants are combinational, with 1-cycle memory read latency.
module prn_memcode_arbiter #(
   parameter int CH_NUM = 4
) (
   input  logic clk,
   input  logic rst_b,
   prn_memcode_arbiter_if.slave bus
);
   localparam int PW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [CH_NUM-1:0] ch_mask_q, ch_mask_d;
   logic              host_block_q, host_block_d;
   logic [13:0]       mem_addr_q, mem_addr_d;

   logic [13:0]       addr_arr [CH_NUM];
   logic [CH_NUM-1:0] elig, grant;
   logic [PW-1:0]     sel;
   logic              found, host_go, ch_go;

   genvar k;
   generate
      for (k = 0; k < CH_NUM; k++) begin : g_addr
         assign addr_arr[k] = bus.ch_addr[14*k +: 14];
      end
   endgenerate

   always_comb begin
      int idx;
      idx          = 0;
      elig         = bus.ch_rd & ~ch_mask_q;
      sel          = rr_ptr_q;
      found        = 1'b0;
      // Rotating search starting at the pointer; the first eligible channel wins.
      for (int i = 0; i < CH_NUM; i++) begin
         idx = (int'(rr_ptr_q) + i) % CH_NUM;
         if (!found && elig[idx]) begin
            found = 1'b1;
            sel   = PW'(idx);
         end
      end
      // Gating with rst_b keeps the combinational outputs at their reset values during reset.
      host_go      = rst_b & bus.host_cs & ~host_block_q;
      ch_go        = rst_b & ~host_go & found;
      grant        = '0;
      if (ch_go) grant[sel] = 1'b1;
      rr_ptr_d     = rr_ptr_q;
      if (ch_go) rr_ptr_d = (sel == PW'(CH_NUM - 1)) ? '0 : sel + 1'b1;
      ch_mask_d    = grant;
      host_block_d = host_go;
      mem_addr_d   = mem_addr_q;
      if (host_go)    mem_addr_d = bus.host_addr;
      else if (ch_go) mem_addr_d = addr_arr[sel];
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         rr_ptr_q     <= '0;
         ch_mask_q    <= '0;
         host_block_q <= 1'b0;
         mem_addr_q   <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         ch_mask_q    <= ch_mask_d;
         host_block_q <= host_block_d;
         mem_addr_q   <= mem_addr_d;
      end
   end

   assign bus.ch_read_valid = grant;
   assign bus.ch_data       = bus.mem_rdata;
   assign bus.host_rdata    = bus.mem_rdata;
   assign bus.host_ready    = host_block_q;
   assign bus.mem_en        = host_go | ch_go;
   assign bus.mem_we        = host_go & bus.host_wr;
   assign bus.mem_addr      = mem_addr_d;
   assign bus.mem_wdata     = bus.host_wdata;
endmodule

// File: doc/prn_memcode_arbiter.md
# prn_memcode_arbiter

Shared code-memory arbiter for the correlator array. It serves the memory-code PRN generators of every correlation channel from one single-port synchronous code memory (1-cycle read latency). Channel reads are scheduled round-robin. A host port, used for loading code tables and reading them back, has strict priority over the channels. Each channel sees a private read handshake and a broadcast read-data bus.

## Interface
- CH_NUM, default 4: number of channel requesters (2..16).
- clk  in  1  system clock; all state updates on its rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- ch_rd  in  CH_NUM  per-channel read request, level; held until granted.
- ch_addr  in  14*CH_NUM  per-channel word address; channel k occupies bits [14k+13:14k].
- ch_read_valid  out  CH_NUM  one-hot grant pulse, combinational, in the cycle the channel's address is issued.
- ch_data  out  32  broadcast read data = mem_rdata; valid for channel k in the cycle after its grant.
- host_cs  in  1  host access request, held until host_ready.
- host_wr  in  1  1 = write, 0 = read; qualified by host_cs.
- host_addr  in  14  host word address.
- host_wdata  in  32  host write data.
- host_rdata  out  32  = mem_rdata; valid when host_ready=1 for a read.
- host_ready  out  1  registered completion pulse, one cycle after the host access is issued.
- mem_en  out  1  memory enable, combinational.
- mem_we  out  1  memory write enable, combinational.
- mem_addr  out  14  memory address.
- mem_wdata  out  32  memory write data (= host_wdata).
- mem_rdata  in  32  memory read data; valid the cycle after mem_en with mem_we=0.

## Operation
- One memory access per cycle at most. Each cycle the arbiter selects exactly one of: host, one channel, or idle.
- Host priority:
  - host_cs=1 and host_block=0: host is issued.
  - mem_en=1, mem_we=host_wr, mem_addr=host_addr.
  - host_block is set for the next cycle, which forces host_ready=1 in that cycle.
  - host_block prevents re-issuing the same access while the host deasserts host_cs.
- Channel eligibility: ch_rd[k]=1 and ch_mask[k]=0.
  - ch_mask is a registered copy of the previous cycle's grant vector.
  - A just-granted channel cannot be regranted in the following cycle, which covers its rd-deassert latency.
- Round-robin:
  - A pointer rr_ptr (log2 CH_NUM bits) holds the highest-priority channel.
  - Search order is rr_ptr, rr_ptr+1, …, wrapping modulo CH_NUM.
  - The first eligible channel g is granted: ch_read_valid[g]=1, mem_en=1, mem_we=0, mem_addr=ch_addr[g].
  - rr_ptr is then set to (g+1) mod CH_NUM.
  - rr_ptr is unchanged on host or idle cycles.
- Channels lose the cycle whenever the host is issued. Their ch_rd stays asserted and they are served later, with no loss.
- Write/read ordering: a host write issued at cycle T is visible to any read issued at T+1 or later.
- Idle (no eligible requester): mem_en=0, mem_we=0. mem_addr holds its last value (don't-care).
- Non-granted channels must ignore ch_data.

## Timing
- Reset values:
  - ch_read_valid=0, host_ready=0, mem_en=0, mem_we=0, mem_addr=0.
  - rr_ptr=0, ch_mask=0, host_block=0.
- Channel latency:
  - Request asserted at cycle T with no contention: grant at T, data on ch_data at T+1.
  - Worst-case wait: CH_NUM-1 cycles of channel contention, plus every cycle in which the host is issued.
- Host latency:
  - Issued at T, host_ready=1 at T+1.
  - The host must drop host_cs at T+1, or may start a new access; a new access is accepted no earlier than T+2.
  - Back-to-back host accesses therefore issue every 2 cycles. Channels may use the T+1 slot.
- ch_read_valid and mem_en are combinational from ch_rd, host_cs and registered state. There is no combinational path from mem_rdata to any control output.
- Reset mid-operation:
  - All registered state returns to reset values asynchronously.
  - A pending host_ready pulse and in-flight data are discarded; no host_ready is produced for an access issued before reset.
- ch_rd dropped before grant: the request is withdrawn and no grant occurs.
- rr_ptr wrap: after a grant to channel CH_NUM-1, rr_ptr=0.

## Test plan
- Single request, CH_NUM=4, all idle: ch_rd[2]=1, ch_addr[2]=0x0123 at T. Expect ch_read_valid=4'b0100 and mem_addr=0x0123 at T, then ch_data=mem_rdata at T+1. rr_ptr becomes 3.
- Full contention from reset: ch_rd=4'b1111, each channel dropping rd the cycle after its grant. Expect grants 0,1,2,3 on four consecutive cycles, then rr_ptr=0.
- Fairness: channels 1 and 3 held asserted continuously (masked one cycle after each grant), rr_ptr=2. Expect grants 3,1,3,1,…; channel 1 never regranted on consecutive cycles.
- Host preemption: host write of 0xDEADBEEF to 0x0040 at T while ch_rd[0]=1. Expect mem_we=1 and no ch_read_valid at T, host_ready at T+1, channel 0 granted at T+1. A host read of 0x0040 issued at T+2 returns 0xDEADBEEF with host_ready at T+3.
- Reset mid-access: host read issued at T, rst_b=0 during T+1. Expect host_ready=0, mem_en=0, rr_ptr=0 immediately. After release, with ch_rd=4'b1000, expect a grant to channel 3 on the first cycle.
